// File: rtl/sipo_frame_ctrl_if.sv
// Downstream word handshake between sipo_frame_ctrl and its consumer.
interface sipo_frame_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // Word producer side
    modport master (output out_data, output out_valid, input out_ready);
    // Word consumer side
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Sequencer for an external WIDTH-bit serial-to-parallel shift register.
// Frames the serial stream on sync, drives the SIPO shift/clear, captures
// each finished word and hands it downstream over valid/ready.
// Optional build macro SIPO_PARITY_EN: adds an even-parity bit after each
// word (bit_in/parity_err ports, PARITY state).
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          CONTINUOUS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              bit_valid,
`ifdef SIPO_PARITY_EN
    input  logic              bit_in,
    output logic              parity_err,
`endif
    input  logic [WIDTH-1:0]  sr_q,
    output logic              sr_shift,
    output logic              sr_clear,
    sipo_frame_ctrl_if.master dn,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              busy
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;
`endif

    state_t        state;
    logic [CW-1:0] count;

    // Shift only qualified bits while framing; the sync-cycle bit is dropped
    assign sr_shift = (state == SHIFT) && bit_valid && !sync;
    assign busy     = (state != IDLE);

    // Framing FSM with registered word, handshake and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            sr_clear     <= 1'b0;
            dn.out_data  <= '0;
            dn.out_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            sr_clear <= 1'b0;
            if (dn.out_valid && dn.out_ready) begin
                dn.out_valid <= 1'b0;
            end
            if (ovr_clr) begin
                overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (sync) begin
                        state    <= SHIFT;
                        count    <= '0;
                        sr_clear <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sync) begin
                        count    <= '0;
                        sr_clear <= 1'b1;
                    end else if (bit_valid) begin
                        if (count == CW'(WIDTH - 1)) begin
                            count <= '0;
`ifdef SIPO_PARITY_EN
                            state <= PARITY;
`else
                            state <= CAPTURE;
`endif
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (sync) begin
                        state    <= SHIFT;
                        count    <= '0;
                        sr_clear <= 1'b1;
                    end else if (bit_valid) begin
                        if (^{sr_q, bit_in}) begin
                            parity_err <= 1'b1;
                            state      <= CONTINUOUS ? SHIFT : IDLE;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
`endif
                CAPTURE: begin
                    // Reload when the holding register is free or being emptied now
                    if (!dn.out_valid || dn.out_ready) begin
                        dn.out_data  <= sr_q;
                        dn.out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    count <= '0;
                    if (sync) begin
                        state    <= SHIFT;
                        sr_clear <= 1'b1;
                    end else begin
                        state <= CONTINUOUS ? SHIFT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: a continuous-mode and a single-word instance,
// each with its own shift-register model and word scoreboard.
module tb_sipo_frame_ctrl;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sync = 1'b0, bit_valid = 1'b0, sd = 1'b0, tgt = 1'b0, ovr_clr = 1'b0;
    logic a_sync, a_bv, b_sync, b_bv;

    always #5 clk = ~clk;

    // tgt selects which instance sees sync/bit_valid
    assign a_sync = sync & ~tgt;
    assign a_bv   = bit_valid & ~tgt;
    assign b_sync = sync & tgt;
    assign b_bv   = bit_valid & tgt;

    sipo_frame_ctrl_if #(.WIDTH(W)) a_if ();
    sipo_frame_ctrl_if #(.WIDTH(W)) b_if ();

    logic [W-1:0] a_sr = '0;
    logic [W-1:0] b_sr = '0;
    logic a_shift, a_clear, a_ovr, a_busy;
    logic b_shift, b_clear, b_ovr, b_busy;
`ifdef SIPO_PARITY_EN
    logic a_perr, b_perr;
`endif

    sipo_frame_ctrl #(.WIDTH(W), .CONTINUOUS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .sync(a_sync), .bit_valid(a_bv),
`ifdef SIPO_PARITY_EN
        .bit_in(sd), .parity_err(a_perr),
`endif
        .sr_q(a_sr), .sr_shift(a_shift), .sr_clear(a_clear), .dn(a_if.master),
        .overrun(a_ovr), .ovr_clr(ovr_clr), .busy(a_busy)
    );

    sipo_frame_ctrl #(.WIDTH(W), .CONTINUOUS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .sync(b_sync), .bit_valid(b_bv),
`ifdef SIPO_PARITY_EN
        .bit_in(sd), .parity_err(b_perr),
`endif
        .sr_q(b_sr), .sr_shift(b_shift), .sr_clear(b_clear), .dn(b_if.master),
        .overrun(b_ovr), .ovr_clr(ovr_clr), .busy(b_busy)
    );

    // External SIPO models, MSB first, clear has priority
    always @(posedge clk) begin
        if (a_clear) a_sr <= '0;
        else if (a_shift) a_sr <= {a_sr[W-2:0], sd};
        if (b_clear) b_sr <= '0;
        else if (b_shift) b_sr <= {b_sr[W-2:0], sd};
    end

    int checks = 0;
    int errors = 0;
    int clr_a = 0, shift_b = 0, hs_b = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expectation
    always @(negedge clk) begin
        if (a_clear) clr_a++;
        if (b_shift) shift_b++;
        if (reset && a_if.out_valid && a_if.out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_word actual=%0h required=none", a_if.out_data);
            end else begin
                chk("a_word", 64'(a_if.out_data), 64'(qa.pop_front()));
            end
        end
        if (reset && b_if.out_valid && b_if.out_ready) begin
            hs_b++;
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_word actual=%0h required=none", b_if.out_data);
            end else begin
                chk("b_word", 64'(b_if.out_data), 64'(qb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sync pulse followed by the sr_clear cycle left idle
    task automatic send_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [W-1:0] w);
        for (int i = 0; i < int'(W); i++) begin
            sd = w[W-1-i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_par(input logic p);
        sd = p;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    // Data bits plus (when built in) the matching parity bit; ends one edge before capture
    task automatic send_word(input logic [W-1:0] w);
        send_bits(w);
`ifdef SIPO_PARITY_EN
        send_par(^w);
`endif
    endtask

    // Whole word including the idle capture cycle
    task automatic send_frame(input logic [W-1:0] w);
        send_word(w);
        tick();
    endtask

    int c0, s0;

    initial begin
        a_if.out_ready = 1'b0;
        b_if.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_shift", 64'(a_shift), 64'd0);
        chk("rst_clear", 64'(a_clear), 64'd0);
        chk("rst_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_data", 64'(a_if.out_data), 64'd0);
        chk("rst_ovr", 64'(a_ovr), 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Single word, two-edge latency, accepted in one cycle
        a_if.out_ready = 1'b1;
        send_sync();
        chk("t2_busy", 64'(a_busy), 64'd1);
        qa.push_back(16'hA5C3);
        send_word(16'hA5C3);
        chk("t2_lat_edge1", 64'(a_if.out_valid), 64'd0);
        tick();
        chk("t2_lat_edge2", 64'(a_if.out_valid), 64'd1);
        chk("t2_data", 64'(a_if.out_data), 64'hA5C3);
        tick();
        chk("t2_accepted", 64'(a_if.out_valid), 64'd0);

        // Back-to-back words against a stalled consumer
        a_if.out_ready = 1'b0;
        qa.push_back(16'h1234);
        send_frame(16'h1234);
        send_frame(16'hBEEF);
        chk("t3_ovr_set", 64'(a_ovr), 64'd1);
        chk("t3_valid_held", 64'(a_if.out_valid), 64'd1);
        chk("t3_data_held", 64'(a_if.out_data), 64'h1234);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", 64'(a_ovr), 64'd0);
        chk("t3_data_still", 64'(a_if.out_data), 64'h1234);
        a_if.out_ready = 1'b1;
        tick();
        chk("t3_drained", 64'(a_if.out_valid), 64'd0);

        // Abort a partial word with a second sync
        c0 = clr_a;
        send_sync();
        for (int i = 0; i < 9; i++) begin
            sd = i[0];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        send_sync();
        qa.push_back(16'h00FF);
        send_frame(16'h00FF);
        chk("t4_clear_pulses", 64'(clr_a - c0), 64'd2);
        tick();

        // Asynchronous reset in the middle of a word
        a_if.out_ready = 1'b0;
        send_frame(16'h5A5A);
        chk("t1_pre_valid", 64'(a_if.out_valid), 64'd1);
        send_sync();
        for (int i = 0; i < 7; i++) begin
            sd = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        chk("t1_pre_shift", 64'(a_shift), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("t1_busy", 64'(a_busy), 64'd0);
        chk("t1_shift", 64'(a_shift), 64'd0);
        chk("t1_clear", 64'(a_clear), 64'd0);
        chk("t1_valid", 64'(a_if.out_valid), 64'd0);
        chk("t1_data", 64'(a_if.out_data), 64'd0);
        chk("t1_ovr", 64'(a_ovr), 64'd0);
        bit_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Single-word mode ignores bits until the next sync
        tgt = 1'b1;
        b_if.out_ready = 1'b1;
        send_sync();
        qb.push_back(16'h3C5A);
        send_frame(16'h3C5A);
        chk("t5_busy_after", 64'(b_busy), 64'd0);
        s0 = shift_b;
        send_word(16'hFFFF);
        tick();
        chk("t5_no_shift", 64'(shift_b - s0), 64'd0);
        chk("t5_busy_idle", 64'(b_busy), 64'd0);
        chk("t5_one_word", 64'(hs_b), 64'd1);
        tgt = 1'b0;

`ifdef SIPO_PARITY_EN
        // Parity: good bit captures, bad bit discards and flags
        a_if.out_ready = 1'b1;
        send_sync();
        qa.push_back(16'h0001);
        send_bits(16'h0001);
        send_par(1'b1);
        tick();
        chk("t6_good_valid", 64'(a_if.out_valid), 64'd1);
        chk("t6_good_perr", 64'(a_perr), 64'd0);
        tick();
        send_sync();
        send_bits(16'h0001);
        send_par(1'b0);
        chk("t6_bad_perr", 64'(a_perr), 64'd1);
        tick();
        chk("t6_bad_valid", 64'(a_if.out_valid), 64'd0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t6_perr_clr", 64'(a_perr), 64'd0);
`endif

        tick();
        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
